// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage and Data_Memory.
// Hits complete combinationally; misses write back a dirty victim and then fetch the line.
module dcache_controller #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned LINE_W   = 256,
    parameter int unsigned INDEX_W  = 5,
    parameter int unsigned OFFSET_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i
);

    localparam int unsigned TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned LINES  = 1 << INDEX_W;
    localparam int unsigned WSEL_W = OFFSET_W - 2;

    typedef enum logic [1:0] {
        StIdle,
        StWb,
        StFetch,
        StRefill
    } state_e;

    state_e state_q, state_d;

    logic [LINES-1:0]  valid_q, valid_d;
    logic [LINES-1:0]  dirty_q, dirty_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [TAG_W-1:0]  tag_d  [LINES];
    logic [LINE_W-1:0] data_q [LINES];
    logic [LINE_W-1:0] data_d [LINES];

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [WSEL_W-1:0]   word_sel;
    logic [WSEL_W+4:0]   word_bit;
    logic [TAG_W-1:0]    cur_tag;
    logic [LINE_W-1:0]   cur_line;
    logic                hit;
    logic                write_hit;
    logic                refill;
    logic                unused_addr_lsb;

    assign req_tag   = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign req_index = cpu_addr_i[OFFSET_W +: INDEX_W];
    assign word_sel  = cpu_addr_i[OFFSET_W-1:2];
    assign word_bit  = {word_sel, 5'b00000};
    // Byte offset within the word is irrelevant for word-only accesses.
    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    assign cur_tag    = tag_q[req_index];
    assign cur_line   = data_q[req_index];
    assign hit        = valid_q[req_index] && (cur_tag == req_tag);
    assign cpu_data_o = cur_line[word_bit +: 32];

    always_comb begin
        state_d      = state_q;
        cpu_stall_o  = 1'b0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        write_hit    = 1'b0;
        refill       = 1'b0;
        unique case (state_q)
            StIdle: begin
                cpu_stall_o = cpu_req_i && !hit;
                if (cpu_req_i) begin
                    if (hit) begin
                        write_hit = cpu_we_i;
                    end else if (valid_q[req_index] && dirty_q[req_index]) begin
                        state_d = StWb;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StWb: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {cur_tag, req_index, {OFFSET_W{1'b0}}};
                mem_data_o   = cur_line;
                if (mem_ack_i) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag, req_index, {OFFSET_W{1'b0}}};
                if (mem_ack_i) begin
                    state_d = StRefill;
                end
            end
            StRefill: begin
                // Fetched data is only valid the cycle after the ack.
                cpu_stall_o = 1'b1;
                refill      = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (refill) begin
            valid_d[req_index] = 1'b1;
            dirty_d[req_index] = 1'b0;
            tag_d[req_index]   = req_tag;
            data_d[req_index]  = mem_data_i;
        end else if (write_hit) begin
            dirty_d[req_index]                 = 1'b1;
            data_d[req_index][word_bit +: 32] = cpu_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays are plain registers without reset; valid gates their use.
    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a 10-cycle line-transfer responder model.
// Transfer latency counts exclude the combinational miss-detect cycle in IDLE.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_ack_i;
    logic [255:0] mem_data_i;

    dcache_controller dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_enable_o(mem_enable_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_ack_i   (mem_ack_i),
        .mem_data_i  (mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Responder memory: untouched lines hold word(addr) = addr ^ 0x5A5A0000.
    logic [255:0] mem_model [logic [31:0]];
    logic         ack_en = 1'b1;
    int           resp_cnt = 0;
    logic         fill_pending = 1'b0;
    logic [255:0] fill_line;
    int           rd_cnt = 0;
    int           wr_cnt = 0;
    logic [31:0]  last_rd_addr = '0;
    logic [31:0]  last_wr_addr = '0;
    logic [255:0] last_wr_data = '0;
    int           unstable = 0;
    int           spurious = 0;
    logic         prev_en = 1'b0;
    logic         prev_wr = 1'b0;
    logic [31:0]  prev_addr = '0;
    logic [255:0] prev_data = '0;

    function automatic logic [255:0] mem_read(input logic [31:0] a);
        logic [255:0] l;
        if (mem_model.exists(a)) return mem_model[a];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = (a + 32'(w * 4)) ^ 32'h5A5A_0000;
        return l;
    endfunction

    always @(negedge clk_i) begin
        if (mem_enable_o && prev_en && mem_write_o == prev_wr &&
            (mem_addr_o != prev_addr || mem_data_o != prev_data)) unstable++;
        if (mem_enable_o && fill_pending) spurious++;
        prev_en   = mem_enable_o;
        prev_wr   = mem_write_o;
        prev_addr = mem_addr_o;
        prev_data = mem_data_o;

        mem_data_i   = fill_pending ? fill_line : {8{32'hBAD0_BAD0}};
        fill_pending = 1'b0;
        mem_ack_i    = 1'b0;
        if (rst_i || !mem_enable_o) begin
            resp_cnt = 0;
        end else if (ack_en) begin
            resp_cnt++;
            if (resp_cnt == 10) begin
                resp_cnt  = 0;
                mem_ack_i = 1'b1;
                if (mem_write_o) begin
                    mem_model[mem_addr_o] = mem_data_o;
                    wr_cnt++;
                    last_wr_addr = mem_addr_o;
                    last_wr_data = mem_data_o;
                end else begin
                    fill_line    = mem_read(mem_addr_o);
                    fill_pending = 1'b1;
                    rd_cnt++;
                    last_rd_addr = mem_addr_o;
                end
            end
        end
    end

    // Waits for the stall to clear, completes the access and drops the request.
    task automatic wait_done(output logic [31:0] rdata, output int n);
        logic timed_out;
        n = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (!cpu_stall_o) begin
                timed_out = 1'b0;
                break;
            end
            n++;
        end
        check("done_timeout", 64'(timed_out), 64'd0);
        rdata = cpu_data_o;
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
    endtask

    task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk_i);
        #1;
        cpu_req_i  = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_data_i = wdata;
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int n);
        start_req(we, addr, wdata);
        wait_done(rdata, n);
    endtask

    logic [31:0] rd;
    int          n;

    initial begin
        rst_i      = 1'b1;
        cpu_req_i  = 1'b0;
        cpu_we_i   = 1'b0;
        cpu_addr_i = '0;
        cpu_data_i = '0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        repeat (2) @(negedge clk_i);
        check("rst_stall", 64'(cpu_stall_o), 64'd0);
        check("rst_enable", 64'(mem_enable_o), 64'd0);
        check("rst_write", 64'(mem_write_o), 64'd0);
        check("rst_addr", 64'(mem_addr_o), 64'd0);
        check("rst_data", 64'(|mem_data_o), 64'd0);
        rst_i = 1'b0;

        // 1: cold load miss
        access(1'b0, 32'h100, '0, rd, n);
        check("t1_wait", 64'(n - 1), 64'd11);
        check("t1_data", 64'(rd), 64'h5A5A_0100);
        check("t1_fetch_addr", 64'(last_rd_addr), 64'h100);
        check("t1_no_wb", 64'(wr_cnt), 64'd0);

        // 2: store hit, then load it back
        access(1'b1, 32'h104, 32'hDEAD_BEEF, rd, n);
        check("t2_store_stall", 64'(n), 64'd0);
        access(1'b0, 32'h104, '0, rd, n);
        check("t2_load_stall", 64'(n), 64'd0);
        check("t2_load_data", 64'(rd), 64'hDEAD_BEEF);
        access(1'b0, 32'h100, '0, rd, n);
        check("t2_other_word", 64'(rd), 64'h5A5A_0100);

        // 3: conflicting tag on index 8 evicts the dirty line
        access(1'b0, 32'h500, '0, rd, n);
        check("t3_wait", 64'(n - 1), 64'd21);
        check("t3_wb_count", 64'(wr_cnt), 64'd1);
        check("t3_wb_addr", 64'(last_wr_addr), 64'h100);
        check("t3_wb_word1", 64'(last_wr_data[63:32]), 64'hDEAD_BEEF);
        check("t3_wb_word0", 64'(last_wr_data[31:0]), 64'h5A5A_0100);
        check("t3_fetch_addr", 64'(last_rd_addr), 64'h500);
        check("t3_data", 64'(rd), 64'h5A5A_0500);

        // 4: clean miss back to 0x100 sees the written-back word
        access(1'b0, 32'h104, '0, rd, n);
        check("t4_wait", 64'(n - 1), 64'd11);
        check("t4_no_wb", 64'(wr_cnt), 64'd1);
        check("t4_fetch_addr", 64'(last_rd_addr), 64'h100);
        check("t4_data", 64'(rd), 64'hDEAD_BEEF);

        // 5: reset in the middle of a fetch
        start_req(1'b0, 32'h500, '0);
        repeat (4) @(negedge clk_i);
        check("t5_fetch_active", {31'd0, mem_enable_o, mem_write_o, mem_addr_o},
              {31'd0, 1'b1, 1'b0, 32'h500});
        #2;
        rst_i = 1'b1;
        #1;
        check("t5_rst_enable", 64'(mem_enable_o), 64'd0);
        check("t5_rst_addr", 64'(mem_addr_o), 64'd0);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("t5_remiss", 64'(cpu_stall_o), 64'd1);
        wait_done(rd, n);
        check("t5_data", 64'(rd), 64'h5A5A_0500);
        check("t5_fetch_addr", 64'(last_rd_addr), 64'h500);

        // 6: responder withholds the ack
        ack_en = 1'b0;
        start_req(1'b0, 32'h200, '0);
        @(negedge clk_i);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk_i);
            check("t6_hold", {29'd0, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o},
                  {29'd0, 3'b110, 32'h200});
        end
        ack_en = 1'b1;
        wait_done(rd, n);
        check("t6_data", 64'(rd), 64'h5A5A_0200);

        check("fetch_total", 64'(rd_cnt), 64'd5);
        check("wb_total", 64'(wr_cnt), 64'd1);
        check("addr_data_stable", 64'(unstable), 64'd0);
        check("no_spurious_xfer", 64'(spurious), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
